// File: rtl/cs_encode_scheduler.sv
// Stream-side scheduler for the (2,3) cyclic-shift parity encoder: pairs symbols, issues them,
// serializes the coded triple. Define CS_SCHED_STATS_EN to enable the gen/pad statistics counters.
module cs_encode_scheduler #(
    parameter int WIDTH   = 4,
    parameter int ENC_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             enc_valid_in,
    output logic [WIDTH-1:0] enc_data_0,
    output logic [WIDTH-1:0] enc_data_1,
    input  logic             enc_valid_out,
    input  logic [WIDTH-1:0] enc_coded_0,
    input  logic [WIDTH-1:0] enc_coded_1,
    input  logic [WIDTH-1:0] enc_coded_2,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       m_idx,
    output logic             m_last,
    output logic             m_pad,
    output logic             busy,
    output logic             lat_err,
    output logic [CNT_W-1:0] gen_count,
    output logic [CNT_W-1:0] pad_count
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALF  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4
    } state_t;

    localparam logic [3:0] LAT_M1   = 4'(ENC_LAT - 1);
    localparam logic [3:0] WAIT_MAX = 4'd15;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] d0_r, enc_d0_r, enc_d1_r;
    logic [WIDTH-1:0] cap0_r, cap1_r, cap2_r, m_data_s;
    logic [1:0]       idx_r;
    logic [3:0]       wait_cnt_r;
    logic             pad_r, last_r, lat_err_r;
    logic             s_fire_s, m_fire_s, wait_to_s;

    assign s_ready   = ((state_r == IDLE) || (state_r == HALF)) && !rst;
    assign s_fire_s  = s_valid && s_ready;
    assign m_fire_s  = (state_r == SEND) && m_ready;
    assign wait_to_s = (state_r == WAIT) && !enc_valid_out && (wait_cnt_r == WAIT_MAX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = s_fire_s ? (s_last ? ISSUE : HALF) : IDLE;
            HALF:    state_s = s_fire_s ? ISSUE : HALF;
            ISSUE:   state_s = WAIT;
            WAIT:    state_s = (enc_valid_out || wait_to_s) ? SEND : WAIT;
            SEND:    state_s = (m_fire_s && (idx_r == 2'd2)) ? IDLE : SEND;
            default: state_s = IDLE;
        endcase
    end

    // Generation holding registers, wait counter, capture and output index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_r       <= '0;
            enc_d0_r   <= '0;
            enc_d1_r   <= '0;
            cap0_r     <= '0;
            cap1_r     <= '0;
            cap2_r     <= '0;
            idx_r      <= 2'd0;
            wait_cnt_r <= 4'd0;
            pad_r      <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (s_fire_s) begin
                        d0_r   <= s_data;
                        pad_r  <= s_last;
                        last_r <= s_last;
                        // Single-symbol packet: load the issue registers directly with zero padding
                        if (s_last) begin
                            enc_d0_r <= s_data;
                            enc_d1_r <= '0;
                        end else begin
                            enc_d0_r <= enc_d0_r;
                        end
                    end else begin
                        d0_r <= d0_r;
                    end
                end
                HALF: begin
                    if (s_fire_s) begin
                        enc_d0_r <= d0_r;
                        enc_d1_r <= s_data;
                        last_r   <= s_last;
                    end else begin
                        enc_d0_r <= enc_d0_r;
                    end
                end
                ISSUE: wait_cnt_r <= 4'd0;
                WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 4'd1;
                    idx_r      <= 2'd0;
                    if (enc_valid_out) begin
                        cap0_r <= enc_coded_0;
                        cap1_r <= enc_coded_1;
                        cap2_r <= enc_coded_2;
                    end else if (wait_to_s) begin
                        cap0_r <= '0;
                        cap1_r <= '0;
                        cap2_r <= '0;
                    end else begin
                        cap0_r <= cap0_r;
                    end
                end
                SEND: begin
                    if (m_fire_s) begin
                        idx_r <= (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: idx_r <= 2'd0;
            endcase
        end
    end

    // Sticky latency error: early/late result, timeout, or result outside WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_err_r <= 1'b0;
        end else if ((enc_valid_out && (state_r != WAIT)) ||
                     (enc_valid_out && (state_r == WAIT) && (wait_cnt_r != LAT_M1)) ||
                     wait_to_s) begin
            lat_err_r <= 1'b1;
        end else begin
            lat_err_r <= lat_err_r;
        end
    end

    // Coded symbol select for the serializer
    always_comb begin
        m_data_s = cap2_r;
        case (idx_r)
            2'd0:    m_data_s = cap0_r;
            2'd1:    m_data_s = cap1_r;
            default: m_data_s = cap2_r;
        endcase
    end

    assign enc_valid_in = (state_r == ISSUE);
    assign enc_data_0   = enc_d0_r;
    assign enc_data_1   = enc_d1_r;
    assign m_valid      = (state_r == SEND);
    assign m_data       = m_data_s;
    assign m_idx        = idx_r;
    assign m_last       = (state_r == SEND) && last_r && (idx_r == 2'd2);
    assign m_pad        = (state_r == SEND) && pad_r;
    assign busy         = (state_r != IDLE);
    assign lat_err      = lat_err_r;

`ifdef CS_SCHED_STATS_EN
    logic [CNT_W-1:0] gen_cnt_r, pad_cnt_r;

    // Statistics: counted on the issue cycle, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_cnt_r <= '0;
            pad_cnt_r <= '0;
        end else if (state_r == ISSUE) begin
            gen_cnt_r <= gen_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            pad_cnt_r <= pad_cnt_r + {{(CNT_W-1){1'b0}}, pad_r};
        end else begin
            gen_cnt_r <= gen_cnt_r;
        end
    end

    assign gen_count = gen_cnt_r;
    assign pad_count = pad_cnt_r;
`else
    assign gen_count = '0;
    assign pad_count = '0;
`endif

endmodule
